// File: rtl/master_port.sv
// master_port: initiator end of the serial system bus. Latches one local request, wins the bus,
// shifts out device address, mode, memory address and write data, and collects read data.
// Optional ack timeout: define MASTER_PORT_ACK_TIMEOUT_EN.
module master_port #(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 8,
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int ACK_TIMEOUT       = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req,
  input  logic                         req_wen,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_dev,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         req_ready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         done,
  output logic                         err,
  output logic                         mbreq,
  input  logic                         mbgrant,
  output logic                         mvalid,
  output logic                         mwdata,
  input  logic                         ack,
  input  logic                         srdata,
  input  logic                         srvalid,
  input  logic                         sready,
  input  logic                         ssplit,
  input  logic                         split_grant
);

  localparam int SH_W_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int SH_W    = (SH_W_AD > DEVICE_ADDR_WIDTH) ? SH_W_AD : DEVICE_ADDR_WIDTH;
  localparam int CNT_W   = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEV_BITS  = CNT_W'(DEVICE_ADDR_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(DATA_WIDTH - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GRANT = 4'd1;
  localparam logic [3:0] S_DEV   = 4'd2;
  localparam logic [3:0] S_ACKW  = 4'd3;
  localparam logic [3:0] S_HDR   = 4'd4;
  localparam logic [3:0] S_WDAT  = 4'd5;
  localparam logic [3:0] S_RESP  = 4'd6;
  localparam logic [3:0] S_RDAT  = 4'd7;
  localparam logic [3:0] S_SPLIT = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]                   state_q, state_d;
  logic [3:0]                   ret_q, ret_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SH_W-1:0]              sh_q, sh_d;
  logic                         req_ready_q, req_ready_d;
  logic                         mbreq_q, mbreq_d;
  logic                         mvalid_q, mvalid_d;
  logic                         mwdata_q, mwdata_d;
  logic                         done_q, done_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;

  logic                         wen_q;
  logic [DEVICE_ADDR_WIDTH-1:0] dev_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic                         accept;

  assign accept = (state_q == S_IDLE) && req && req_ready_q;

`ifdef MASTER_PORT_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic            err_q, err_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;

  assign err = err_q;
`else
  localparam int ack_timeout_unused = ACK_TIMEOUT;

  assign err = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path through the case infers a latch.
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    req_ready_d = req_ready_q;
    mbreq_d     = mbreq_q;
    mvalid_d    = mvalid_q;
    mwdata_d    = mwdata_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
    err_d       = 1'b0;
    tcnt_d      = tcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          mbreq_d     = 1'b1;
          state_d     = S_GRANT;
        end
      end

      S_GRANT: begin
        if (mbgrant) begin
          mvalid_d = 1'b1;
          mwdata_d = dev_q[0];
          sh_d     = SH_W'(dev_q >> 1);
          cnt_d    = CNT_ONE;
          state_d  = S_DEV;
        end
      end

      S_DEV: begin
        if (cnt_q == DEV_BITS) begin
          mvalid_d = 1'b0;
          mwdata_d = 1'b0;
          state_d  = S_ACKW;
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
          tcnt_d   = TO_ONE;
`endif
        end else begin
          mwdata_d = sh_q[0];
          sh_d     = sh_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end

      S_ACKW: begin
        // Ack is checked ahead of the timeout so an ack in the expiry cycle still proceeds.
        if (ack) begin
          mvalid_d = 1'b1;
          mwdata_d = wen_q;
          sh_d     = SH_W'(addr_q);
          cnt_d    = '0;
          state_d  = S_HDR;
        end
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
        else if (tcnt_q == TO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          mbreq_d = 1'b0;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TO_ONE;
        end
`endif
      end

      S_HDR: begin
        if (cnt_q != ADDR_BITS) begin
          mwdata_d = sh_q[0];
          sh_d     = sh_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
        end else if (wen_q) begin
          mwdata_d = wdata_q[0];
          sh_d     = SH_W'(wdata_q >> 1);
          cnt_d    = CNT_ONE;
          state_d  = S_WDAT;
        end else begin
          mvalid_d = 1'b0;
          mwdata_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RDAT;
        end
      end

      S_WDAT: begin
        if (cnt_q == DATA_BITS) begin
          mvalid_d = 1'b0;
          mwdata_d = 1'b0;
          state_d  = S_RESP;
        end else begin
          mwdata_d = sh_q[0];
          sh_d     = sh_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
        end
      end

      S_RESP: begin
        if (sready) begin
          done_d  = 1'b1;
          mbreq_d = 1'b0;
          state_d = S_DONE;
        end else if (ssplit) begin
          mbreq_d = 1'b0;
          ret_d   = S_RESP;
          state_d = S_SPLIT;
        end
      end

      S_RDAT: begin
        if (srvalid) begin
          rdata_d = {srdata, rdata_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_ONE;
        end
        // The final sample completes the read even if the slave also signals a split.
        if (srvalid && (cnt_q == RD_LAST)) begin
          done_d  = 1'b1;
          mbreq_d = 1'b0;
          state_d = S_DONE;
        end else if (ssplit) begin
          mbreq_d = 1'b0;
          ret_d   = S_RDAT;
          state_d = S_SPLIT;
        end
      end

      S_SPLIT: begin
        if (split_grant) begin
          mbreq_d = 1'b1;
          state_d = ret_q;
        end
      end

      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ret_q       <= S_RDAT;
      cnt_q       <= '0;
      sh_q        <= '0;
      req_ready_q <= 1'b1;
      mbreq_q     <= 1'b0;
      mvalid_q    <= 1'b0;
      mwdata_q    <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
      err_q       <= 1'b0;
      tcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      req_ready_q <= req_ready_d;
      mbreq_q     <= mbreq_d;
      mvalid_q    <= mvalid_d;
      mwdata_q    <= mwdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
`ifdef MASTER_PORT_ACK_TIMEOUT_EN
      err_q       <= err_d;
      tcnt_q      <= tcnt_d;
`endif
    end
  end

  // NOTE: the request holding register is always loaded before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      dev_q   <= req_dev;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign mbreq     = mbreq_q;
  assign mvalid    = mvalid_q;
  assign mwdata    = mwdata_q;
  assign done      = done_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: directed bench for master_port with hand-derived serial streams and responses.
// The ack-timeout case runs only when MASTER_PORT_ACK_TIMEOUT_EN is defined.
module tb_master_port;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int DVW = 4;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           req = 1'b0;
  logic           req_wen = 1'b0;
  logic [DVW-1:0] req_dev = '0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic           req_ready;
  logic [DW-1:0]  rdata;
  logic           done;
  logic           err;
  logic           mbreq;
  logic           mbgrant = 1'b0;
  logic           mvalid;
  logic           mwdata;
  logic           ack = 1'b0;
  logic           srdata = 1'b0;
  logic           srvalid = 1'b0;
  logic           sready = 1'b0;
  logic           ssplit = 1'b0;
  logic           split_grant = 1'b0;

  master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEVICE_ADDR_WIDTH(DVW), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_wen(req_wen), .req_dev(req_dev),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata),
    .done(done), .err(err), .mbreq(mbreq), .mbgrant(mbgrant), .mvalid(mvalid),
    .mwdata(mwdata), .ack(ack), .srdata(srdata), .srvalid(srvalid), .sready(sready),
    .ssplit(ssplit), .split_grant(split_grant)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input string tag, input logic wen, input logic [DVW-1:0] dev,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit hold);
    req = 1'b1; req_wen = wen; req_dev = dev; req_addr = addr; req_wdata = wdata;
    step();
    if (!hold) req = 1'b0;
    check({tag, ".ready_lo"}, req_ready, 0);
    check({tag, ".mbreq_hi"}, mbreq, 1);
  endtask

  task automatic expect_serial(input string tag, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.mvalid[%0d]", tag, i), mvalid, 1);
      check($sformatf("%s.bit[%0d]", tag, i), mwdata, bits[i]);
      step();
    end
  endtask

  task automatic addr_phase(input string tag, input logic [DVW-1:0] dev, input int gdelay,
                            input int adelay);
    for (int k = 1; k < gdelay; k++) begin
      check({tag, ".idle_bus"}, mvalid, 0);
      step();
    end
    mbgrant = 1'b1;
    step();
    expect_serial({tag, ".dev"}, 64'(dev), DVW);
    for (int k = 1; k < adelay; k++) begin
      check({tag, ".ackw_mvalid"}, mvalid, 0);
      step();
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic resp_phase(input string tag, input int rdelay, input logic with_split);
    for (int k = 1; k < rdelay; k++) begin
      check({tag, ".resp_mvalid"}, mvalid, 0);
      check({tag, ".resp_nodone"}, done, 0);
      step();
    end
    sready = 1'b1; ssplit = with_split;
    step();
    sready = 1'b0; ssplit = 1'b0;
    check({tag, ".done"}, done, 1);
    check({tag, ".err"}, err, 0);
    check({tag, ".mbreq_drop"}, mbreq, 0);
    mbgrant = 1'b0;
  endtask

  task automatic read_phase(input string tag, input logic [DW-1:0] data, input int split_after,
                            input int split_wait, input logic final_split);
    for (int i = 0; i < DW; i++) begin
      if (split_after > 0 && i == split_after) begin
        ssplit = 1'b1;
        step();
        ssplit = 1'b0;
        for (int k = 0; k < split_wait; k++) begin
          check({tag, ".split_mbreq"}, mbreq, 0);
          check({tag, ".split_nodone"}, done, 0);
          step();
        end
        split_grant = 1'b1;
        step();
        split_grant = 1'b0;
        check({tag, ".resume_mbreq"}, mbreq, 1);
      end
      srvalid = 1'b1; srdata = data[i]; ssplit = final_split && (i == DW - 1);
      step();
      srvalid = 1'b0; ssplit = 1'b0;
      if (i < DW - 1) begin
        check({tag, ".nodone"}, done, 0);
        step();
      end
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".err"}, err, 0);
    check({tag, ".rdata"}, rdata, 32'(data));
    mbgrant = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int start_cnt);
    step();
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".ready_back"}, req_ready, 1);
    check({tag, ".mbreq_idle"}, mbreq, 0);
    check({tag, ".one_done"}, 32'(done_cnt - start_cnt), 1);
  endtask

  initial begin
    int start;

    // Reset values
    step();
    check("rst.req_ready", req_ready, 1);
    check("rst.mbreq", mbreq, 0);
    check("rst.mvalid", mvalid, 0);
    check("rst.mwdata", mwdata, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.rdata", rdata, 0);
    rstn = 1'b1;
    step();

    // 1. Reset in the middle of the device-address phase
    start = done_cnt;
    accept_req("t1", 1'b1, 4'hF, 16'h1111, 8'h22, 1'b0);
    mbgrant = 1'b1;
    step();
    check("t1.dev_bit0", mvalid, 1);
    step();
    rstn = 1'b0;
    #1;
    check("t1.rst_mvalid", mvalid, 0);
    check("t1.rst_mbreq", mbreq, 0);
    check("t1.rst_ready", req_ready, 1);
    check("t1.rst_done", done, 0);
    step();
    rstn = 1'b1;
    mbgrant = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("t1.post_mvalid", mvalid, 0);
      check("t1.post_ready", req_ready, 1);
      step();
    end
    check("t1.no_done", 32'(done_cnt - start), 0);

    // 2. Write dev=2 addr=00A5 data=3C
    start = done_cnt;
    accept_req("t2", 1'b1, 4'h2, 16'h00A5, 8'h3C, 1'b0);
    req_dev = 4'hD; req_addr = 16'hFFFF; req_wdata = 8'hFF;
    addr_phase("t2", 4'h2, 3, 2);
    expect_serial("t2.hdr", 64'({8'h3C, 16'h00A5, 1'b1}), 1 + AW + DW);
    resp_phase("t2", 4, 1'b0);
    finish_check("t2", start);

    // 3. Read dev=1 addr=0010, slave returns 96 with gaps; split on final bit loses to completion
    start = done_cnt;
    accept_req("t3", 1'b0, 4'h1, 16'h0010, 8'h00, 1'b0);
    addr_phase("t3", 4'h1, 1, 3);
    expect_serial("t3.hdr", 64'({16'h0010, 1'b0}), 1 + AW);
    read_phase("t3", 8'h96, 0, 0, 1'b1);
    finish_check("t3", start);

    // 4. Read with a split after three bits, resumed ten cycles later
    start = done_cnt;
    accept_req("t4", 1'b0, 4'h5, 16'h1234, 8'h00, 1'b0);
    addr_phase("t4", 4'h5, 2, 1);
    expect_serial("t4.hdr", 64'({16'h1234, 1'b0}), 1 + AW);
    read_phase("t4", 8'h5A, 3, 10, 1'b0);
    finish_check("t4", start);

`ifdef MASTER_PORT_ACK_TIMEOUT_EN
    // 5. No ack: error completion ACK_TIMEOUT cycles after the last device bit
    start = done_cnt;
    accept_req("t5", 1'b1, 4'h3, 16'hAAAA, 8'h55, 1'b0);
    mbgrant = 1'b1;
    step();
    expect_serial("t5.dev", 64'(4'h3), DVW);
    for (int k = 1; k < TO; k++) begin
      check("t5.wait_nodone", done, 0);
      check("t5.wait_mvalid", mvalid, 0);
      step();
    end
    check("t5.done", done, 1);
    check("t5.err", err, 1);
    check("t5.mbreq", mbreq, 0);
    mbgrant = 1'b0;
    finish_check("t5", start);
    check("t5.err_clear", err, 0);
`endif

    // 6. req held high: back-to-back writes, second accepted only after done; sready beats ssplit
    start = done_cnt;
    accept_req("t6a", 1'b1, 4'h6, 16'hBEEF, 8'h81, 1'b1);
    req_dev = 4'h9; req_addr = 16'h0F0F; req_wdata = 8'hC3;
    addr_phase("t6a", 4'h6, 1, 1);
    expect_serial("t6a.hdr", 64'({8'h81, 16'hBEEF, 1'b1}), 1 + AW + DW);
    resp_phase("t6a", 1, 1'b1);
    check("t6.done_ready", req_ready, 0);
    step();
    check("t6.gap_ready", req_ready, 1);
    check("t6.gap_done", done, 0);
    check("t6.gap_mbreq", mbreq, 0);
    step();
    req = 1'b0;
    check("t6b.ready_lo", req_ready, 0);
    check("t6b.mbreq_hi", mbreq, 1);
    addr_phase("t6b", 4'h9, 2, 2);
    expect_serial("t6b.hdr", 64'({8'hC3, 16'h0F0F, 1'b1}), 1 + AW + DW);
    resp_phase("t6b", 2, 1'b0);
    step();
    check("t6.two_done", 32'(done_cnt - start), 2);
    check("t6.final_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
